// File: rtl/dmem_lsu_pkg.sv
// Shared encodings for the data-memory load/store sequencer.
// Covers access sizes, FSM states and the default response watchdog limit.
package dmem_lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam int unsigned DEF_RVALID_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'b00,
        ST_REQ         = 2'b01,
        ST_WAIT_RVALID = 2'b10,
        ST_MISAL       = 2'b11
    } lsu_state_e;

    // Reserved size 2'b11 falls into the word rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_lsu_ctrl_if.sv
// Core-side request/response signals and OBI-style data bus signals of the LSU.
// Modport master is the sequencer's view; slave is the core + memory view.
interface dmem_lsu_ctrl_if;

    logic        i_lsu_req;
    logic        i_lsu_we;
    logic [1:0]  i_lsu_size;
    logic        i_lsu_unsigned;
    logic [31:0] i_lsu_addr;
    logic [31:0] i_lsu_wdata;
    logic        o_lsu_busy;
    logic        o_lsu_done;
    logic [31:0] o_lsu_rdata;
    logic        o_lsu_err;
    logic        o_lsu_misaligned;

    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        data_err_i;

    modport master (
        input  i_lsu_req, i_lsu_we, i_lsu_size, i_lsu_unsigned, i_lsu_addr, i_lsu_wdata,
        output o_lsu_busy, o_lsu_done, o_lsu_rdata, o_lsu_err, o_lsu_misaligned,
        output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
    );

    modport slave (
        output i_lsu_req, i_lsu_we, i_lsu_size, i_lsu_unsigned, i_lsu_addr, i_lsu_wdata,
        input  o_lsu_busy, o_lsu_done, o_lsu_rdata, o_lsu_err, o_lsu_misaligned,
        input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
    );

endinterface

// File: rtl/dmem_lsu_align.sv
// Combinational lane logic: byte enables and store-data replication,
// plus load-data right shift with sign/zero extension.
module dmem_lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] rdata_shifted;

    assign rdata_shifted = rdata_raw >> {addr_lo, 3'b000};

    // Word and the reserved size keep the defaults: all lanes, no shift or extension.
    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata_raw;
        case (size)
            SIZE_B: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{~is_unsigned & rdata_shifted[7]}}, rdata_shifted[7:0]};
            end
            SIZE_H: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{~is_unsigned & rdata_shifted[15]}}, rdata_shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer: latches one core access, runs req/gnt/rvalid on the data
// bus with a response watchdog, and returns a registered one-cycle completion.
module dmem_lsu_ctrl
    import dmem_lsu_pkg::*;
#(
    parameter int unsigned RVALID_TIMEOUT = DEF_RVALID_TIMEOUT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    dmem_lsu_ctrl_if.master bus
);

    localparam int unsigned     CNT_W     = $clog2(RVALID_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(RVALID_TIMEOUT);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             latch_en;
    logic             we_q, uns_q;
    logic [1:0]       size_q;
    logic [31:0]      addr_q, wdata_q;
    logic             done_q, done_d, err_q, err_d, mis_q, mis_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [3:0]       be;
    logic [31:0]      wdata_rep, rdata_ext;
    logic             in_req;

    dmem_lsu_align u_align (
        .size        (size_q),
        .addr_lo     (addr_q[1:0]),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rdata_raw   (bus.data_rdata_i),
        .be          (be),
        .wdata_rep   (wdata_rep),
        .rdata_ext   (rdata_ext)
    );

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        mis_d    = 1'b0;
        rdata_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_lsu_req) begin
                    latch_en = 1'b1;
                    state_d  = is_misaligned(bus.i_lsu_size, bus.i_lsu_addr[1:0]) ? ST_MISAL : ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.data_gnt_i) begin
                    state_d = ST_WAIT_RVALID;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_RVALID: begin
                cnt_d = cnt_inc;
                // A response landing on the watchdog limit cycle still counts as a response.
                if (bus.data_rvalid_i) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    err_d   = bus.data_err_i;
                    rdata_d = (we_q || bus.data_err_i) ? '0 : rdata_ext;
                end else if (cnt_inc == CNT_LIMIT) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            ST_MISAL: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                mis_d   = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (latch_en) begin
            we_q    <= bus.i_lsu_we;
            uns_q   <= bus.i_lsu_unsigned;
            size_q  <= bus.i_lsu_size;
            addr_q  <= bus.i_lsu_addr;
            wdata_q <= bus.i_lsu_wdata;
        end
    end

    // Bus attributes are only driven while requesting, so reset and idle show all zeros.
    assign in_req           = (state_q == ST_REQ);
    assign bus.data_req_o   = in_req;
    assign bus.data_we_o    = in_req & we_q;
    assign bus.data_be_o    = in_req ? be : 4'b0000;
    assign bus.data_addr_o  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus.data_wdata_o = in_req ? wdata_rep : 32'h0;

    assign bus.o_lsu_busy       = (state_q != ST_IDLE);
    assign bus.o_lsu_done       = done_q;
    assign bus.o_lsu_err        = err_q;
    assign bus.o_lsu_misaligned = mis_q;
    assign bus.o_lsu_rdata      = rdata_q;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Directed scoreboard bench for dmem_lsu_ctrl with a scripted memory responder.
module tb_dmem_lsu_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        mis;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    int          gnt_delay = 0;
    int          rv_delay = 0;
    logic        rv_en = 1'b1;
    logic [31:0] rv_rdata = 32'h0;
    logic        rv_err = 1'b0;
    logic [31:0] exp_bus_addr = 32'h0;
    logic [31:0] exp_bus_wdata = 32'h0;
    logic [3:0]  exp_bus_be = 4'h0;
    logic        exp_bus_we = 1'b0;

    dmem_lsu_ctrl_if bus ();

    dmem_lsu_ctrl #(.RVALID_TIMEOUT(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkBus(input string tag);
        checkOutput({tag, "_addr"}, bus.data_addr_o, exp_bus_addr);
        checkOutput({tag, "_be"}, 32'(bus.data_be_o), 32'(exp_bus_be));
        checkOutput({tag, "_wdata"}, bus.data_wdata_o, exp_bus_wdata);
        checkOutput({tag, "_we"}, 32'(bus.data_we_o), 32'(exp_bus_we));
    endtask

    task automatic setMem(input int gd, input logic en, input int rd, input logic [31:0] data, input logic err);
        gnt_delay = gd;
        rv_en     = en;
        rv_delay  = rd;
        rv_rdata  = data;
        rv_err    = err;
    endtask

    task automatic setBus(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata, input logic we);
        exp_bus_addr  = addr;
        exp_bus_be    = be;
        exp_bus_wdata = wdata;
        exp_bus_we    = we;
    endtask

    // Called at a negedge; lat is n in "done in cycle T+n" where T is the accepting edge.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] e_rdata, input logic e_err, input logic e_mis,
                                 input int lat);
        exp_t e;
        e.rdata = e_rdata;
        e.err   = e_err;
        e.mis   = e_mis;
        e.cyc   = cyc + lat;
        sb.push_back(e);
        bus.i_lsu_req      = 1'b1;
        bus.i_lsu_we       = we;
        bus.i_lsu_size     = size;
        bus.i_lsu_unsigned = uns;
        bus.i_lsu_addr     = addr;
        bus.i_lsu_wdata    = wdata;
        @(posedge clk);
        #1;
        bus.i_lsu_req = 1'b0;
        checkOutput("busy_after_accept", 32'(bus.o_lsu_busy), 32'd1);
    endtask

    task automatic waitDone(input bit no_req);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (no_req) checkOutput("misal_no_req", 32'(bus.data_req_o), 32'd0);
        end
        checkOutput("done_within_budget", sb.size(), 0);
        if (sb.size() != 0) sb.delete();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.o_lsu_done === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 32'(bus.o_lsu_done), 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("done_cycle", cyc, e.cyc);
                checkOutput("done_rdata", bus.o_lsu_rdata, e.rdata);
                checkOutput("done_err", 32'(bus.o_lsu_err), 32'(e.err));
                checkOutput("done_mis", 32'(bus.o_lsu_misaligned), 32'(e.mis));
                checkOutput("done_busy", 32'(bus.o_lsu_busy), 32'd0);
            end
        end else begin
            checkOutput("quiet_rdata", bus.o_lsu_rdata, 32'h0);
            checkOutput("quiet_err", 32'(bus.o_lsu_err), 32'd0);
            checkOutput("quiet_mis", 32'(bus.o_lsu_misaligned), 32'd0);
        end
    end

    // Memory responder: grants after gnt_delay extra cycles, answers after rv_delay extra cycles.
    initial begin
        bus.data_gnt_i    = 1'b0;
        bus.data_rvalid_i = 1'b0;
        bus.data_rdata_i  = 32'h0;
        bus.data_err_i    = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.data_req_o === 1'b1) begin
                checkBus("req_first");
                repeat (gnt_delay) begin
                    @(posedge clk);
                    @(negedge clk);
                    checkOutput("req_held", 32'(bus.data_req_o), 32'd1);
                    checkBus("req_held");
                end
                bus.data_gnt_i = 1'b1;
                @(posedge clk);
                #1;
                bus.data_gnt_i = 1'b0;
                if (rv_en) begin
                    repeat (rv_delay) begin
                        @(posedge clk);
                        #1;
                    end
                    bus.data_rvalid_i = 1'b1;
                    bus.data_rdata_i  = rv_rdata;
                    bus.data_err_i    = rv_err;
                    @(posedge clk);
                    #1;
                    bus.data_rvalid_i = 1'b0;
                    bus.data_rdata_i  = 32'h0;
                    bus.data_err_i    = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, observed time %0t", $time);
        $fatal(1, "[TB] aborting");
    end

    initial begin
        bus.i_lsu_req      = 1'b0;
        bus.i_lsu_we       = 1'b0;
        bus.i_lsu_size     = 2'b00;
        bus.i_lsu_unsigned = 1'b0;
        bus.i_lsu_addr     = 32'h0;
        bus.i_lsu_wdata    = 32'h0;

        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(bus.o_lsu_busy), 32'd0);
        checkOutput("rst_req", 32'(bus.data_req_o), 32'd0);
        checkOutput("rst_done", 32'(bus.o_lsu_done), 32'd0);
        setBus(32'h0, 4'h0, 32'h0, 1'b0);
        checkBus("rst");
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_busy", 32'(bus.o_lsu_busy), 32'd0);

        $display("[TB] LW zero-wait");
        setMem(0, 1'b1, 0, 32'hDEADBEEF, 1'b0);
        setBus(32'h100, 4'b1111, 32'h0, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 3);
        waitDone(1'b0);

        $display("[TB] LB / LBU upper lane");
        setMem(0, 1'b1, 0, 32'h80123456, 1'b0);
        setBus(32'h100, 4'b1000, 32'h0, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0, 3);
        waitDone(1'b0);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h00000080, 1'b0, 1'b0, 3);
        waitDone(1'b0);

        $display("[TB] SH with delayed grant");
        setMem(3, 1'b1, 0, 32'hFFFFFFFF, 1'b0);
        setBus(32'h200, 4'b1100, 32'hABCDABCD, 1'b1);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 32'h0, 1'b0, 1'b0, 6);
        waitDone(1'b0);

        $display("[TB] misaligned LW / LH");
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 1'b0, 1'b1, 2);
        waitDone(1'b1);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h203, 32'h0, 32'h0, 1'b0, 1'b1, 2);
        waitDone(1'b1);

        $display("[TB] LH signed with slow response, LHU low lane");
        setMem(0, 1'b1, 2, 32'h80011234, 1'b0);
        setBus(32'h100, 4'b1100, 32'h0, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'hFFFF8001, 1'b0, 1'b0, 5);
        waitDone(1'b0);
        setMem(0, 1'b1, 0, 32'h1234F00D, 1'b0);
        setBus(32'h100, 4'b0011, 32'h0, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 32'h0000F00D, 1'b0, 1'b0, 3);
        waitDone(1'b0);

        $display("[TB] SB lane 1, reserved size as word");
        setMem(0, 1'b1, 0, 32'h11111111, 1'b0);
        setBus(32'h100, 4'b0010, 32'hA5A5A5A5, 1'b1);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h101, 32'h000000A5, 32'h0, 1'b0, 1'b0, 3);
        waitDone(1'b0);
        setMem(0, 1'b1, 0, 32'hCAFEF00D, 1'b0);
        setBus(32'h500, 4'b1111, 32'h76543210, 1'b0);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h500, 32'h76543210, 32'hCAFEF00D, 1'b0, 1'b0, 3);
        waitDone(1'b0);

        $display("[TB] watchdog timeout, bus error, response on limit cycle");
        setMem(0, 1'b0, 0, 32'h0, 1'b0);
        setBus(32'h300, 4'b1111, 32'h0, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h0, 1'b1, 1'b0, 6);
        waitDone(1'b0);
        setMem(0, 1'b1, 0, 32'h12345678, 1'b1);
        setBus(32'h400, 4'b1111, 32'h0, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 1'b0, 3);
        waitDone(1'b0);
        setMem(0, 1'b1, 3, 32'h55AA55AA, 1'b0);
        setBus(32'h404, 4'b1111, 32'h0, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h404, 32'h0, 32'h55AA55AA, 1'b0, 1'b0, 6);
        waitDone(1'b0);

        $display("[TB] reset during WAIT_RVALID with stale response");
        setMem(0, 1'b1, 6, 32'h0BAD0BAD, 1'b0);
        setBus(32'h600, 4'b1111, 32'h0, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h600, 32'h0, 32'h0, 1'b0, 1'b0, 3);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        checkOutput("midrst_busy", 32'(bus.o_lsu_busy), 32'd0);
        checkOutput("midrst_req", 32'(bus.data_req_o), 32'd0);
        checkOutput("midrst_done", 32'(bus.o_lsu_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            checkOutput("stale_busy", 32'(bus.o_lsu_busy), 32'd0);
            checkOutput("stale_done", 32'(bus.o_lsu_done), 32'd0);
        end

        $display("[TB] normal access after reset");
        setMem(0, 1'b1, 0, 32'h01020304, 1'b0);
        setBus(32'h700, 4'b1111, 32'h0, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h700, 32'h0, 32'h01020304, 1'b0, 1'b0, 3);
        waitDone(1'b0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_lsu_ctrl.md
# dmem_lsu_ctrl

Load/store sequencer between the core execute stage and the data-memory port. It accepts one load or store per request, generates byte enables and write-data lane replication, and runs the OBI-style req/gnt/rvalid handshake as a registered FSM. It stalls the core while a transfer is outstanding and returns sign- or zero-extended load data. Misaligned accesses and bus errors are trapped, and a watchdog bounds the wait for a response.

## Interface
- `RVALID_TIMEOUT`, default 255: max cycles spent in WAIT_RVALID before abort; legal range 1..65535.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `i_lsu_req` in 1: access request, sampled only in IDLE.
- `i_lsu_we` in 1: 1 = store, 0 = load.
- `i_lsu_size` in 2: 00 byte, 01 half, 10 word; 11 reserved, treated as word.
- `i_lsu_unsigned` in 1: zero-extend load (LBU/LHU).
- `i_lsu_addr` in 32: byte address.
- `i_lsu_wdata` in 32: store data, right-aligned.
- `o_lsu_busy` out 1: stall; high whenever state != IDLE.
- `o_lsu_done` out 1: one-cycle completion pulse.
- `o_lsu_rdata` out 32: extended load data, valid with done; 0 for stores and errors.
- `o_lsu_err` out 1: bus error or timeout, valid with done.
- `o_lsu_misaligned` out 1: misaligned access, valid with done.
- `data_req_o` out 1: bus request.
- `data_we_o` out 1: bus write enable.
- `data_be_o` out 4: byte enables.
- `data_addr_o` out 32: word-aligned address ({addr[31:2],2'b00}).
- `data_wdata_o` out 32: lane-replicated store data.
- `data_gnt_i` in 1: grant.
- `data_rvalid_i` in 1: response valid.
- `data_rdata_i` in 32: response data.
- `data_err_i` in 1: response error, qualified by rvalid.

## Operation
- States: IDLE, REQ, WAIT_RVALID, MISAL.
- IDLE + `i_lsu_req`: latch we/size/unsigned/addr/wdata.
  - Next state REQ if aligned.
  - Next state MISAL if half with addr[0]=1, or word with addr[1:0]!=0.
- REQ:
  - `data_req_o`=1.
  - addr, be, we and wdata are held stable from the latched values until `data_gnt_i`.
  - On gnt, go to WAIT_RVALID and clear the timeout counter.
- WAIT_RVALID:
  - `data_req_o`=0; the counter increments each cycle.
  - On `data_rvalid_i`: go to IDLE and register done=1, err=`data_err_i`, rdata=extended data (0 if store or err).
  - If the counter reaches RVALID_TIMEOUT without rvalid: go to IDLE with done=1, err=1, rdata=0.
- MISAL: no bus transaction. Go to IDLE with done=1, misaligned=1, err=0, rdata=0.
- Byte enables:
  - byte: 4'b0001<<addr[1:0].
  - half: 4'b0011<<{addr[1],1'b0}.
  - word: 4'b1111.
- Write data:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: as is.
- Read data: shift right by addr[1:0]*8, then sign-extend from bit 7 or 15 unless unsigned; word passes through unchanged.
- `data_rvalid_i` outside WAIT_RVALID is ignored, including a stale response after reset.
- Reset (async, any state):
  - State=IDLE, counter=0, latches=0.
  - All outputs 0; the bus request is dropped immediately.

## Timing
- Request accepted at edge T: REQ during T+1, `data_req_o` high in cycle T+1.
- Zero-wait memory (gnt in T+1, rvalid in T+2): `o_lsu_done` high in cycle T+3. Minimum latency is 3 cycles.
- Each gnt wait cycle adds 1; each rvalid wait cycle adds 1.
- Misaligned access: done in cycle T+2.
- done, rdata, err and misaligned are registered, valid for exactly one cycle, and 0 otherwise.
- Done cycle is IDLE (busy=0), so a new request may be accepted at the same edge that ends done. Back-to-back throughput: one access per 3 cycles.
- Timeout: done asserted RVALID_TIMEOUT+1 cycles after the gnt edge.
- rvalid arriving in the same cycle the counter hits the limit: rvalid wins, err=`data_err_i`.

## Structure
- `dmem_lsu_pkg` holds:
  - size encodings (SIZE_B/H/W);
  - state encoding (2-bit);
  - default RVALID_TIMEOUT.
- Sub-module `dmem_lsu_align` is purely combinational. It computes be and replicated wdata from size/addr[1:0], and extended rdata from size/unsigned/addr[1:0].
- Top module holds the FSM, latches, watchdog counter ($clog2(RVALID_TIMEOUT+1) bits) and output registers.

## Test plan
- LW addr 0x100, gnt same cycle, rvalid next, rdata 0xDEADBEEF -> be=1111, addr_o=0x100, done at T+3, rdata=0xDEADBEEF, err=0.
- LB addr 0x103, rdata 0x80xxxxxx -> be=1000, rdata=0xFFFFFF80. Same access as LBU -> rdata=0x00000080.
- SH addr 0x202, wdata 0x1234ABCD, gnt delayed 3 cycles:
  - req/addr/be=1100/wdata=0xABCDABCD stable across the wait;
  - done at T+6, rdata=0.
- LW addr 0x101 -> no `data_req_o` ever, done at T+2 with misaligned=1.
- RVALID_TIMEOUT=4, gnt but no rvalid -> done with err=1 five cycles after the gnt edge. rvalid with `data_err_i`=1 -> err=1, rdata=0.
- Reset asserted in WAIT_RVALID, then rvalid arrives after reset release -> outputs 0 immediately, no done pulse, next request completes normally.
